level_max_locate: RTL and testbench
===================================

LEVEL_MAX_LOCATE -- requirements
Module: level_max_locate

Interface
REQ-001 Parameter SCORE_W, default 7: unsigned similarity-score width; equals the max1..max4 width.
REQ-002 Parameter COLS, default 13: score columns per level; equals the loc1..loc4 width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle request to begin a 4-level frame.
REQ-007 s_valid  in  1  score beat valid.
REQ-008 s_ready  out  1  block accepts a score beat this cycle.
REQ-009 s_score  in  SCORE_W  unsigned score; beat k of a level is column k (0..COLS-1).
REQ-010 max1..max4  out  SCORE_W each  per-level maximum score.
REQ-011 loc1..loc4  out  COLS each  per-level location mask of the maximum; bit k = column k.
REQ-012 busy  out  1  frame in progress.
REQ-013 done  out  1  all four levels complete; consumer-facing finish flag.

Function
REQ-014 States SHALL be IDLE, SCAN, DONE; encoding is held in the shared package.
REQ-015 IDLE->SCAN on start; DONE->SCAN on start; start in SCAN SHALL be ignored.
REQ-016 On entering SCAN: level=0, col=0, running max=0, running mask=0, done=0, busy=1; max1..4/loc1..4 SHALL be cleared to 0.
REQ-017 s_ready SHALL be 1 only in SCAN; a beat transfers when s_valid&&s_ready; s_valid outside SCAN SHALL be ignored.
REQ-018 Beat at col 0 SHALL load running max=s_score and mask=1<<0 unconditionally.
REQ-019 Beat at col>0: s_score>max (unsigned) SHALL load max=s_score, mask=1<<col; s_score==max SHALL apply the tie rule (REQ-030); s_score<max SHALL leave both unchanged.
REQ-020 col SHALL increment per beat; on the col=COLS-1 beat, the final max/mask (including that beat) SHALL be written to max<level+1>/loc<level+1> at that same clock edge; col wraps to 0 and level increments.
REQ-021 Beat col=COLS-1 of level 3 SHALL move to DONE; done=1 and busy=0 from the next cycle.
REQ-022 DONE SHALL hold done=1 and all max/loc outputs stable until the next start.
REQ-023 Gaps in s_valid SHALL stall col/level without state change; throughput is one beat per cycle.
REQ-024 Every loc output SHALL be nonzero after its level completes (at least one bit set).

Reset
REQ-025 rst low SHALL asynchronously force state=IDLE, s_ready=0, busy=0, done=0, max1..4=0, loc1..4=0, level=0, col=0.
REQ-026 Reset mid-frame SHALL discard partial results; no output may retain pre-reset values.
REQ-027 After rst rises, the block SHALL remain in IDLE until start.

Configuration
REQ-028 Macro LOC_TIE_ALL_EN selects the tie rule.
REQ-029 Defined: on equality, mask |= 1<<col (all tied columns are marked, so the consumer's nearest-neighbour search sees every maximum).
REQ-030 Undefined: on equality, mask unchanged (lowest-index maximum only; loc is one-hot).

Structure
REQ-031 Package sw_score_pkg SHALL hold SCORE_W, COLS=13, LEVELS=4, the state enum, and the centre constant LOC_CENTRE=13'b0000001000000.
REQ-032 Sub-module level_max_unit SHALL implement the running max/mask compare for one level (inputs: beat, col, first flag; outputs: max, mask); it is instantiated once and reused across levels.

Verification
REQ-033 Level 0 scores 0..12 ascending, others all 5 -> max1=12, loc1=13'h1000; max2..4=5; loc2..4=13'h1FFF with macro, 13'h0001 without.
REQ-034 Level with peak 60 at col 6 only -> max=60, loc=13'b0000001000000; done rises exactly one cycle after the 52nd handshake.
REQ-035 Scores 40 at cols 3 and 9, others 10 -> with macro loc=13'h0208, without loc=13'h0008.
REQ-036 s_valid toggled 1/0 per cycle across a frame -> results identical to the back-to-back run; s_ready=1 throughout SCAN.
REQ-037 rst low after 20 beats -> all outputs 0 immediately; a subsequent start with all-127 scores -> max1..4=127, done=1.
REQ-038 start pulsed during SCAN and in DONE -> SCAN run unaffected; start in DONE clears outputs and restarts.

Source files
------------

// File: rtl/sw_score_pkg.sv
// Shared constants, state encoding and column mask constants for the level max locator.
package sw_score_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned COLS    = 13;
  localparam int unsigned LEVELS  = 4;

  // Mask with only the middle column set, for consumers centring a search window.
  localparam logic [COLS-1:0] LOC_CENTRE = 13'b0000001000000;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/level_max_locate_if.sv
// Score stream carrying one column score per beat, with a valid/ready handshake.
interface level_max_locate_if #(
  parameter int unsigned SCORE_W = sw_score_pkg::SCORE_W
) ();

  logic               s_valid;
  logic               s_ready;
  logic [SCORE_W-1:0] s_score;

  modport master (output s_valid, output s_score, input s_ready);
  modport slave  (input s_valid, input s_score, output s_ready);

endinterface

// File: rtl/level_max_unit.sv
// Running maximum and location mask for one level of scores.
// Tie handling is selected by LOC_TIE_ALL_EN: defined marks every tied column,
// undefined keeps only the lowest-index maximum (one-hot mask).
module level_max_unit #(
  parameter int unsigned SCORE_W = 7,
  parameter int unsigned COLS    = 13,
  parameter int unsigned ColW    = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               beat,
  input  logic               first,
  input  logic [ColW-1:0]    col,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] max,
  output logic [COLS-1:0]    mask
);

  logic [SCORE_W-1:0] max_q;
  logic [COLS-1:0]    mask_q;
  logic [COLS-1:0]    col_bit;

  // Max/mask including the current beat; the top captures these on the last column.
  always_comb begin
    col_bit = COLS'(1) << col;
    max     = max_q;
    mask    = mask_q;
    if (first) begin
      max  = score;
      mask = COLS'(1);
    end else if (score > max_q) begin
      max  = score;
      mask = col_bit;
`ifdef LOC_TIE_ALL_EN
    end else if (score == max_q) begin
      mask = mask_q | col_bit;
`endif
    end
  end

  // Running state advances only on accepted beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q  <= '0;
      mask_q <= '0;
    end else if (clear) begin
      max_q  <= '0;
      mask_q <= '0;
    end else if (beat) begin
      max_q  <= max;
      mask_q <= mask;
    end
  end

endmodule

// File: rtl/level_max_locate.sv
// Four-level maximum/location finder over a stream of column scores.
// Optional macro: LOC_TIE_ALL_EN (mark all tied maxima in the loc masks).
module level_max_locate #(
  parameter int unsigned SCORE_W = sw_score_pkg::SCORE_W,
  parameter int unsigned COLS    = sw_score_pkg::COLS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  level_max_locate_if.slave  s,
  output logic [SCORE_W-1:0] max1,
  output logic [SCORE_W-1:0] max2,
  output logic [SCORE_W-1:0] max3,
  output logic [SCORE_W-1:0] max4,
  output logic [COLS-1:0]    loc1,
  output logic [COLS-1:0]    loc2,
  output logic [COLS-1:0]    loc3,
  output logic [COLS-1:0]    loc4,
  output logic               busy,
  output logic               done
);

  import sw_score_pkg::*;

  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned LevW = $clog2(LEVELS);
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
  localparam logic [LevW-1:0] LevLast = LevW'(LEVELS - 1);

  state_e state_q, state_d;
  logic [LevW-1:0] level_q, level_d;
  logic [ColW-1:0] col_q, col_d;
  logic [SCORE_W-1:0] max_q [LEVELS];
  logic [SCORE_W-1:0] max_d [LEVELS];
  logic [COLS-1:0]    loc_q [LEVELS];
  logic [COLS-1:0]    loc_d [LEVELS];

  logic               fire;
  logic               clear;
  logic [SCORE_W-1:0] unit_max;
  logic [COLS-1:0]    unit_mask;

  assign s.s_ready = (state_q == StScan);
  assign fire      = s.s_valid && s.s_ready;
  assign busy      = (state_q == StScan);
  assign done      = (state_q == StDone);

  level_max_unit #(
    .SCORE_W (SCORE_W),
    .COLS    (COLS),
    .ColW    (ColW)
  ) u_unit (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .beat  (fire),
    .first (col_q == '0),
    .col   (col_q),
    .score (s.s_score),
    .max   (unit_max),
    .mask  (unit_mask)
  );

  // Next-state: start a frame from idle/done, walk columns and levels on each beat.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    col_d   = col_q;
    clear   = 1'b0;
    for (int i = 0; i < LEVELS; i++) begin
      max_d[i] = max_q[i];
      loc_d[i] = loc_q[i];
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StScan;
          level_d = '0;
          col_d   = '0;
          clear   = 1'b1;
          for (int i = 0; i < LEVELS; i++) begin
            max_d[i] = '0;
            loc_d[i] = '0;
          end
        end
      end
      StScan: begin
        if (fire) begin
          if (col_q == ColLast) begin
            max_d[level_q] = unit_max;
            loc_d[level_q] = unit_mask;
            col_d          = '0;
            level_d        = level_q + LevW'(1);
            if (level_q == LevLast) begin
              state_d = StDone;
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset wipes any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      level_q <= '0;
      col_q   <= '0;
      for (int i = 0; i < LEVELS; i++) begin
        max_q[i] <= '0;
        loc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      col_q   <= col_d;
      for (int i = 0; i < LEVELS; i++) begin
        max_q[i] <= max_d[i];
        loc_q[i] <= loc_d[i];
      end
    end
  end

  assign max1 = max_q[0];
  assign max2 = max_q[1];
  assign max3 = max_q[2];
  assign max4 = max_q[3];
  assign loc1 = loc_q[0];
  assign loc2 = loc_q[1];
  assign loc3 = loc_q[2];
  assign loc4 = loc_q[3];

endmodule

// File: tb/tb_level_max_locate.sv
// Bench for level_max_locate: a score-history model predicts every output each cycle,
// and literal expectations pin the model on hand-computed frames.
module tb_level_max_locate;

  typedef logic [6:0] row_t [13];

`ifdef LOC_TIE_ALL_EN
  localparam logic [12:0] ExpLocFlat = 13'h1FFF;
  localparam logic [12:0] ExpLocPair = 13'h0208;
`else
  localparam logic [12:0] ExpLocFlat = 13'h0001;
  localparam logic [12:0] ExpLocPair = 13'h0008;
`endif

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic [6:0]  max1, max2, max3, max4;
  logic [12:0] loc1, loc2, loc3, loc4;
  logic busy, done;

  level_max_locate_if #(.SCORE_W(7)) sif ();

  level_max_locate dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s     (sif),
    .max1  (max1),
    .max2  (max2),
    .max3  (max3),
    .max4  (max4),
    .loc1  (loc1),
    .loc2  (loc2),
    .loc3  (loc3),
    .loc4  (loc4),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: history of the scores accepted in the current frame.
  bit         m_act = 1'b0;
  int         m_n   = 0;
  logic [6:0] m_sc [52];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act <= 1'b0;
      m_n   <= 0;
    end else if (m_act) begin
      if (sif.s_valid) begin
        m_sc[m_n] <= sif.s_score;
        m_n       <= m_n + 1;
        if (m_n == 51) m_act <= 1'b0;
      end
    end else if (start) begin
      m_act <= 1'b1;
      m_n   <= 0;
    end
  end

  function automatic row_t level_row(input int lvl);
    row_t r;
    for (int k = 0; k < 13; k++) r[k] = m_sc[13 * lvl + k];
    return r;
  endfunction

  function automatic logic [6:0] f_max(input row_t r);
    logic [6:0] mx = '0;
    for (int k = 0; k < 13; k++) if (r[k] > mx) mx = r[k];
    return mx;
  endfunction

  function automatic logic [12:0] f_loc(input row_t r);
    logic [6:0]  mx = f_max(r);
    logic [12:0] loc = '0;
    for (int k = 0; k < 13; k++) begin
      if (r[k] == mx) begin
`ifdef LOC_TIE_ALL_EN
        loc[k] = 1'b1;
`else
        if (loc == '0) loc[k] = 1'b1;
`endif
      end
    end
    return loc;
  endfunction

  function automatic logic [6:0] exp_max(input int lvl);
    return (m_n >= 13 * (lvl + 1)) ? f_max(level_row(lvl)) : 7'd0;
  endfunction

  function automatic logic [12:0] exp_loc(input int lvl);
    return (m_n >= 13 * (lvl + 1)) ? f_loc(level_row(lvl)) : 13'd0;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("s_ready", 32'(sif.s_ready), 32'(m_act));
      chk("busy", 32'(busy), 32'(m_act));
      chk("done", 32'(done), 32'(!m_act && m_n == 52));
      chk("max1", 32'(max1), 32'(exp_max(0)));
      chk("max2", 32'(max2), 32'(exp_max(1)));
      chk("max3", 32'(max3), 32'(exp_max(2)));
      chk("max4", 32'(max4), 32'(exp_max(3)));
      chk("loc1", 32'(loc1), 32'(exp_loc(0)));
      chk("loc2", 32'(loc2), 32'(exp_loc(1)));
      chk("loc3", 32'(loc3), 32'(exp_loc(2)));
      chk("loc4", 32'(loc4), 32'(exp_loc(3)));
    end
  end

  function automatic logic [6:0] pat_score(input int pat, input int lvl, input int col);
    case (pat)
      1:       return (lvl == 0) ? 7'(col) : 7'd5;
      2:       return (col == 6) ? 7'd60 : 7'd10;
      3:       return (col == 3 || col == 9) ? 7'd40 : 7'd10;
      4:       return 7'd127;
      default: return 7'((lvl * 37 + col * 53 + 11) % 128);
    endcase
  endfunction

  // Start a frame and feed nbeats scores; optional idle gaps and stray start pulses.
  task automatic run_frame(input int pat, input bit gaps, input bit poke, input int nbeats);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_max1_clr", 32'(max1), 32'd0);
    chk("start_loc4_clr", 32'(loc4), 32'd0);
    for (int n = 0; n < nbeats; n++) begin
      sif.s_valid = 1'b1;
      sif.s_score = pat_score(pat, n / 13, n % 13);
      start       = poke && (n % 9 == 4);
      if (n == 51) begin
        @(negedge clk);
        chk("done_before_last", 32'(done), 32'd0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (gaps) begin
        sif.s_valid = 1'b0;
        sif.s_score = 7'h55;
        @(posedge clk);
        #1;
      end
    end
    sif.s_valid = 1'b0;
    if (nbeats == 52) begin
      @(negedge clk);
      chk("done_after_last", 32'(done), 32'd1);
      chk("busy_after_last", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_score = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(sif.s_ready), 32'd0);
    chk("rst_max1", 32'(max1), 32'd0);
    chk("rst_loc1", 32'(loc1), 32'd0);
    rst = 1'b1;
    chk_on = 1'b1;

    // Valid without start is ignored.
    sif.s_valid = 1'b1;
    sif.s_score = 7'd99;
    repeat (3) @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_max1", 32'(max1), 32'd0);

    // Ascending level 0, flat others.
    run_frame(1, 1'b0, 1'b0, 52);
    chk("p1_max1", 32'(max1), 32'd12);
    chk("p1_loc1", 32'(loc1), 32'h1000);
    chk("p1_max2", 32'(max2), 32'd5);
    chk("p1_loc2", 32'(loc2), 32'(ExpLocFlat));
    chk("p1_loc4", 32'(loc4), 32'(ExpLocFlat));

    // Single centre peak, restarted from DONE.
    run_frame(2, 1'b0, 1'b0, 52);
    chk("p2_max3", 32'(max3), 32'd60);
    chk("p2_loc3", 32'(loc3), 32'(13'b0000001000000));

    // Two tied peaks.
    run_frame(3, 1'b0, 1'b0, 52);
    chk("p3_max2", 32'(max2), 32'd40);
    chk("p3_loc2", 32'(loc2), 32'(ExpLocPair));

    // Same as the first frame with a bubble after every beat.
    run_frame(1, 1'b1, 1'b0, 52);
    chk("gap_max1", 32'(max1), 32'd12);
    chk("gap_loc1", 32'(loc1), 32'h1000);
    chk("gap_loc3", 32'(loc3), 32'(ExpLocFlat));

    // Mixed scores with start pulses during the scan.
    run_frame(5, 1'b0, 1'b1, 52);
    chk("poke_done", 32'(done), 32'd1);

    // Reset mid-frame after 20 beats, then a full-scale frame.
    run_frame(4, 1'b0, 1'b0, 20);
    rst = 1'b0;
    #1;
    chk("mid_rst_max1", 32'(max1), 32'd0);
    chk("mid_rst_loc1", 32'(loc1), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(sif.s_ready), 32'd0);
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_frame(4, 1'b0, 1'b0, 52);
    chk("p4_max1", 32'(max1), 32'd127);
    chk("p4_max4", 32'(max4), 32'd127);
    chk("p4_loc1", 32'(loc1), 32'(ExpLocFlat));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("p4_done_hold", 32'(done), 32'd1);
    chk("p4_max2_hold", 32'(max2), 32'd127);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
